// File: rtl/serial_operand_transmitter_if.sv
// Handshake bundle for serial_operand_transmitter.
//   in_valid/in_ready/in_a/in_b        : parallel operand pair, valid/ready handshake
//   out_valid/out_ready/out_a/out_b    : serial bit pair, valid/ready handshake
//   out_first/out_last                 : word boundary markers on the serial side
// Modport master is the transmitter's view: it consumes the parallel side and
// drives the serial side. Modport slave is the environment around it.
interface serial_operand_transmitter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_a;
  logic             out_b;
  logic             out_first;
  logic             out_last;

  modport master (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_operand_transmitter.sv
// Serializes a pair of WIDTH-bit operands into two lock-step bit streams (MSB
// first when MSB_FIRST=1, LSB first otherwise), with first/last word markers.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : serial_operand_transmitter_if.master (parallel in, serial out handshakes)
// in_ready is combinational (from out_ready and rst); all other outputs come
// straight from registers.
module serial_operand_transmitter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  serial_operand_transmitter_if.master   bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;     // bits remaining after the current one
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             first_q, first_d;

  logic out_valid;
  logic out_last;
  logic xfer;
  logic accept;

  assign out_valid = (state_q == StShift);
  assign out_last  = out_valid & (cnt_q == '0);
  assign xfer      = out_valid & bus.out_ready;
  // A new word may enter while idle, or in the very cycle the last bit leaves.
  assign bus.in_ready = rst & (~out_valid | (xfer & out_last));
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    first_d = first_q;
    if (accept) begin
      state_d = StShift;
      cnt_d   = CntW'(WIDTH - 1);
      sa_d    = bus.in_a;
      sb_d    = bus.in_b;
      first_d = 1'b1;
    end else if (xfer) begin
      first_d = 1'b0;
      if (MSB_FIRST) begin
        sa_d = sa_q << 1;
        sb_d = sb_q << 1;
      end else begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
      end
      if (out_last) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      first_q <= first_d;
    end
  end

  // After a full word every bit has been shifted out, so the registers read 0 when idle.
  assign bus.out_valid = out_valid;
  assign bus.out_a     = MSB_FIRST ? sa_q[WIDTH-1] : sa_q[0];
  assign bus.out_b     = MSB_FIRST ? sb_q[WIDTH-1] : sb_q[0];
  assign bus.out_first = first_q;
  assign bus.out_last  = out_last;

endmodule

// File: doc/serial_operand_transmitter.md
# serial_operand_transmitter

- Serializes pairs of parallel WIDTH-bit operands into two synchronous bit streams, most significant bit first by default.
- Sits upstream of the serial comparators and drives their `a`/`b` inputs.
- Provides a one-cycle word-start marker so the consumer can reset its state between words.
- Accepts words through a valid/ready handshake and holds output bits under downstream back-pressure.

## Interface

Parameters:
- WIDTH, 8: operand width in bits; legal range 1..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  a parallel operand pair is presented.
- in_ready  output  1  the block accepts the pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  out_a/out_b carry a valid bit.
- out_ready  input  1  the consumer takes the current bit this cycle.
- out_a  output  1  serial bit of A.
- out_b  output  1  serial bit of B.
- out_first  output  1  the current bit is the first bit of a word.
- out_last  output  1  the current bit is the last bit of a word.

## Operation

- **Handshakes.**
  - Input accept: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- **States.**
  - IDLE: out_valid=0.
  - SHIFT: out_valid=1; a word is being emitted.
- **Load.**
  - On input accept, in_a/in_b are captured into shift registers.
  - A bit counter is set to WIDTH-1. The counter holds bits remaining after the current bit, with width $clog2(WIDTH), minimum 1.
  - State becomes SHIFT.
- **Transfer in SHIFT.**
  - On each output transfer, both shift registers advance by one bit: shift left if MSB_FIRST, right otherwise.
  - The counter decrements on each output transfer.
  - out_a/out_b are the MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of their shift registers.
- **Stall.** Without an output transfer, all state and outputs hold. A bit must never be dropped or repeated.
- **Flags.**
  - out_first=1 only on the first bit after a load.
  - out_last=1 when the counter is 0.
- **End of word.** On a transfer with out_last=1:
  - If an input accept occurs in the same cycle, the new word loads and state stays SHIFT.
  - Otherwise state returns to IDLE.
- **Ready rule.** in_ready = rst & (state==IDLE | (out_valid & out_ready & out_last)). in_ready is combinational from out_ready.
- **WIDTH=1.** out_first and out_last assert together on the single bit.

## Timing

- **Reset, while rst=0 and on release:**
  - State IDLE.
  - out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0, in_ready=0.
  - Counter and shift registers are 0.
  - in_ready rises in the first cycle after rst=1.
- **Reset mid-word.** Asserting rst in SHIFT aborts the word immediately. No partial bits are emitted after release.
- **Latency.** First bit appears on out_a/out_b the cycle after input accept.
- **Throughput.** With out_ready held at 1, a word takes exactly WIDTH cycles.
- **Back-to-back words.** Continuous in_valid/out_ready gives a 100% output duty cycle: out_valid stays 1 and out_first directly follows out_last.
- **Idle cycles.** Inserting idle cycles between words adds no extra latency beyond the one-cycle load.
- **Input stability.** in_a/in_b are sampled only at input accept. Changes at any other time have no effect.
- **Output stability.** All outputs except in_ready are registered.

## Test plan

- **Reset values.** Hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all outputs 0. Release → in_ready=1 next cycle.
- **Single word, MSB first.** WIDTH=8, MSB_FIRST=1, in_a=8'hA5, in_b=8'h3C, out_ready=1 → out_valid high for 8 cycles starting 1 cycle after accept.
  - out_a = 1,0,1,0,0,1,0,1 and out_b = 0,0,1,1,1,1,0,0.
  - out_first on cycle 1 only, out_last on cycle 8 only.
- **Back-to-back, LSB first.** MSB_FIRST=0, pairs (8'h01,8'h80) then (8'hFF,8'h00), in_valid held → 16 consecutive valid cycles, no gap.
  - out_a = 1,0,0,0,0,0,0,0,1×8; out_b = 0×7,1,0×8.
  - in_ready=1 exactly on the two last-bit cycles plus the initial idle cycle.
- **Back-pressure.** Drop out_ready for 3 cycles after bit 3 of 8'hA5/8'h3C → out_a/out_b/flags hold bit 3 during the stall. Stream resumes with bit 4 and the total delivered sequence is unchanged.
- **Mid-word reset.** Assert rst during bit 5 of a word → out_valid=0 on the same edge (asynchronous). After release, the next accepted word 8'h0F/8'hF0 is sent complete with out_first on its first bit.
- **Comparator hook-up.** WIDTH=1, then WIDTH=8 driving a serial MSB-first comparator, with comparator reset tied to out_first.
  - WIDTH=1: out_first and out_last are both high on every word.
  - WIDTH=8: 8'h40 vs 8'h3F gives a_greater_b=1 on the last bit.
